// File: rtl/dsconv_block_pointwise_scheduler.sv
// Pointwise-conv scheduler: loads one weight vector per filter, streams every
// pixel's channel vector into the PE one beat per cycle, tracks the PE's fixed
// pipeline with a tag shift register and writes each result with its address.
module dsconv_block_pointwise_scheduler #(
  parameter int NUM_PIXELS  = 64,
  parameter int NUM_FILTERS = 32,
  parameter int PE_LATENCY  = 5,
  localparam int PW = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1,
  localparam int FW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1,
  localparam int AW = (NUM_PIXELS * NUM_FILTERS > 1) ? $clog2(NUM_PIXELS * NUM_FILTERS) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_frame_start,
  output logic          o_fmap_rd_en,
  output logic [PW-1:0] o_fmap_addr,
  input  logic [287:0]  i_fmap_rdata,
  output logic          o_wgt_rd_en,
  output logic [FW-1:0] o_wgt_addr,
  input  logic [287:0]  i_wgt_rdata,
  output logic          o_pe_start,
  output logic [287:0]  o_pe_x,
  output logic [287:0]  o_pe_w,
  input  logic [17:0]   i_pe_pixel,
  input  logic          i_pe_ready,
  output logic          o_out_valid,
  output logic [AW-1:0] o_out_addr,
  output logic [17:0]   o_out_data,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err
);

  localparam int LAST_ADDR = NUM_PIXELS * NUM_FILTERS - 1;

  typedef enum logic [1:0] {S_IDLE, S_LOAD_W, S_STREAM, S_DRAIN} state_t;

  state_t        r_state, w_next;
  logic [FW-1:0] r_f;
  logic [PW-1:0] r_p;
  logic [AW-1:0] r_lin;
  logic [287:0]  r_w;
  logic          r_beat;
  logic [AW-1:0] r_beat_addr;
  logic [PE_LATENCY-1:0] r_tag_vld;
  logic [AW-1:0] r_tag_addr [PE_LATENCY];
  logic          r_out_valid;
  logic [AW-1:0] r_out_addr;
  logic [17:0]   r_out_data;
  logic          r_done;
  logic          r_err;

  logic w_accept, w_rd, w_last_p, w_last_f, w_exit_vld, w_exit_last;
  logic [AW-1:0] w_exit_addr;

  assign w_accept    = (r_state == S_IDLE) && i_frame_start;
  assign w_rd        = (r_state == S_STREAM);
  assign w_last_p    = (r_p == PW'(NUM_PIXELS - 1));
  assign w_last_f    = (r_f == FW'(NUM_FILTERS - 1));
  assign w_exit_vld  = r_tag_vld[PE_LATENCY-1];
  assign w_exit_addr = r_tag_addr[PE_LATENCY-1];
  // Results leave the PE in address order, so the final address closes the pass.
  assign w_exit_last = w_exit_vld && (w_exit_addr == AW'(LAST_ADDR));

  // State register.
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (i_frame_start) w_next = S_LOAD_W;
      S_LOAD_W: w_next = S_STREAM;
      S_STREAM: if (w_last_p) w_next = w_last_f ? S_DRAIN : S_LOAD_W;
      S_DRAIN:  if (w_exit_last) w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Filter/pixel counters plus a running linear address for the tags.
  always_ff @(posedge i_clk) begin
    if (!i_rst || w_accept) begin
      r_f   <= '0;
      r_p   <= '0;
      r_lin <= '0;
    end else if (w_rd) begin
      r_lin <= r_lin + AW'(1);
      if (w_last_p) begin
        r_p <= '0;
        if (!w_last_f) r_f <= r_f + FW'(1);
      end else begin
        r_p <= r_p + PW'(1);
      end
    end
  end

  // Weight capture on the first STREAM cycle; the preceding LOAD_W cycle still
  // carries the previous filter's last beat and must see the old weights.
  always_ff @(posedge i_clk) begin
    if (!i_rst)                r_w <= '0;
    else if (w_rd && r_p == '0) r_w <= i_wgt_rdata;
  end

  // p0: beat stage, one cycle after each feature read.
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_beat <= 1'b0;
    else        r_beat <= w_rd;
    r_beat_addr <= r_lin;
  end

  // p1..pN: tag shift register mirroring the PE pipeline depth.
  always_ff @(posedge i_clk) begin
    if (!i_rst) r_tag_vld <= '0;
    else begin
      r_tag_vld[0] <= r_beat;
      for (int i = 1; i < PE_LATENCY; i++) r_tag_vld[i] <= r_tag_vld[i-1];
    end
    r_tag_addr[0] <= r_beat_addr;
    for (int i = 1; i < PE_LATENCY; i++) r_tag_addr[i] <= r_tag_addr[i-1];
  end

  // Output stage: register the PE result when its tag exits.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_out_valid <= 1'b0;
      r_done      <= 1'b0;
      r_out_addr  <= '0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= w_exit_vld;
      r_done      <= w_exit_last;
      if (w_exit_vld) begin
        r_out_addr <= w_exit_addr;
        r_out_data <= i_pe_pixel;
      end
    end
  end

  // Sticky error: a tagged result surfaced before the PE reported ready.
  always_ff @(posedge i_clk) begin
    if (!i_rst || w_accept)            r_err <= 1'b0;
    else if (w_exit_vld && !i_pe_ready) r_err <= 1'b1;
  end

  assign o_fmap_rd_en = w_rd;
  assign o_fmap_addr  = r_p;
  assign o_wgt_rd_en  = (r_state == S_LOAD_W);
  assign o_wgt_addr   = r_f;
  assign o_pe_start   = r_beat;
  assign o_pe_x       = i_fmap_rdata;
  assign o_pe_w       = r_w;
  assign o_out_valid  = r_out_valid;
  assign o_out_addr   = r_out_addr;
  assign o_out_data   = r_out_data;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_busy       = (r_state != S_IDLE) || r_out_valid;

endmodule
